// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// slave = the unit itself, master = the pipeline plus data memory around it.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Handshake: a request transfers on the rising edge where req_valid && req_ready;
  // the requester holds req_valid and its fields stable until then. resp_valid is
  // a single-cycle pulse with no back-pressure, and the flags are valid alongside it.
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-addressed data memory.
// Sub-word stores use read-modify-write; errored requests never touch memory.
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_e;

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  state_e      state_q, state_d;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, word_q;
  logic        accept, illegal, out_of_range, misaligned, req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext, merged;

  // Request checks, evaluated on the live request so errors resolve at acceptance.
  always_comb begin
    accept       = bus.req_valid && (state_q == IDLE);
    illegal      = bus.req_write ? (bus.req_funct3 > 3'd2)
                                 : ((bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'd6));
    out_of_range = ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS_W);
    misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    req_err      = illegal || out_of_range || misaligned;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                                             state_d = RESP;
          else if (bus.req_write && (bus.req_funct3[1:0] == 2'b10)) state_d = WR;
          else                                                     state_d = RD;
        end
      end
      RD:      state_d = write_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane selection for loads and for the merge of sub-word stores.
  always_comb begin
    ld_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'd0:    load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    load_ext = {{16{ld_half[15]}}, ld_half};
      3'd4:    load_ext = {24'h0, ld_byte};
      3'd5:    load_ext = {16'h0, ld_half};
      default: load_ext = bus.mem_rdata;
    endcase
    merged = word_q;
    case (funct3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.mem_read   = (state_q == RD);
    bus.mem_write  = (state_q == WR);
    bus.mem_addr   = ((state_q == RD) || (state_q == WR)) ? {2'b00, addr_q[31:2]} : 32'h0;
    bus.mem_wdata  = (state_q == WR) ? merged : 32'h0;
  end

  // Response fields are written only on the transition into RESP, so they hold between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q             <= 1'b0;
      funct3_q            <= 3'd0;
      addr_q              <= 32'h0;
      wdata_q             <= 32'h0;
      word_q              <= 32'h0;
      bus.resp_rdata      <= 32'h0;
      bus.resp_misaligned <= 1'b0;
      bus.resp_fault      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            write_q  <= bus.req_write;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            if (req_err) begin
              bus.resp_rdata      <= 32'h0;
              bus.resp_fault      <= illegal || out_of_range;
              bus.resp_misaligned <= !(illegal || out_of_range);
            end
          end
        end
        RD: begin
          if (write_q) begin
            word_q <= bus.mem_rdata;
          end else begin
            bus.resp_rdata      <= load_ext;
            bus.resp_fault      <= 1'b0;
            bus.resp_misaligned <= 1'b0;
          end
        end
        WR: begin
          bus.resp_rdata      <= 32'h0;
          bus.resp_fault      <= 1'b0;
          bus.resp_misaligned <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus reset-abort and back-to-back sequences.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_init = 1'b1;
  logic [1:0]  dbg_state;
  logic [31:0] mem [64];
  int          checks = 0;
  int          errors = 0;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Data memory model: combinational read, write on the rising edge.
  assign bus.mem_rdata = (bus.mem_read && (bus.mem_addr < 32'd64)) ? mem[bus.mem_addr[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'h11111111;
      mem[4]  <= 32'h44444444;
      mem[5]  <= 32'h8899AABB;
      mem[63] <= 32'h0A0B0C0D;
    end else if (bus.mem_write && (bus.mem_addr < 32'd64)) begin
      mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end
  end

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_fault;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_wdata;
    int          idx;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_mis, input logic exp_fault, input int exp_lat,
                     input int exp_rd, input int exp_wr, input logic [31:0] exp_wdata,
                     input int idx, input logic [31:0] exp_word);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
    v.exp_mis = exp_mis; v.exp_fault = exp_fault; v.exp_lat = exp_lat;
    v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_wdata = exp_wdata;
    v.idx = idx; v.exp_word = exp_word;
    vecs.push_back(v);
  endtask

  task automatic drive_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int w;
    @(negedge clk);
    w = 0;
    while (!bus.req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int          lat, rd, wrc;
    logic [31:0] wd, wa, rdata;
    logic        mis, flt;
    lat = 0; rd = 0; wrc = 0; wd = 0; wa = 0; rdata = 32'hx; mis = 1'bx; flt = 1'bx;
    drive_req(v.wr, v.f3, v.addr, v.wdata);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (bus.mem_read) rd++;
      if (bus.mem_write) begin
        wrc++;
        wd = bus.mem_wdata;
        wa = bus.mem_addr;
      end
      if (bus.mem_read && bus.mem_write) check($sformatf("v%0d both_strobes", n), 1, 0);
      if (!bus.mem_read && !bus.mem_write)
        check($sformatf("v%0d quiet_bus", n), bus.mem_addr | bus.mem_wdata, 32'h0);
      if (bus.resp_valid) begin
        lat   = k;
        rdata = bus.resp_rdata;
        mis   = bus.resp_misaligned;
        flt   = bus.resp_fault;
        break;
      end
    end
    check($sformatf("v%0d latency", n), lat, v.exp_lat);
    check($sformatf("v%0d rdata", n), rdata, v.exp_rdata);
    check($sformatf("v%0d misaligned", n), {31'h0, mis}, {31'h0, v.exp_mis});
    check($sformatf("v%0d fault", n), {31'h0, flt}, {31'h0, v.exp_fault});
    check($sformatf("v%0d read_count", n), rd, v.exp_rd);
    check($sformatf("v%0d write_count", n), wrc, v.exp_wr);
    if (v.exp_wr > 0) begin
      check($sformatf("v%0d mem_wdata", n), wd, v.exp_wdata);
      check($sformatf("v%0d mem_addr", n), wa, 32'(v.idx));
    end
    check($sformatf("v%0d mem_word", n), mem[v.idx], v.exp_word);
  endtask

  initial begin
    logic [4:0] resp_seen, ready_seen, read_seen;
    logic [31:0] rd_a, rd_b;

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    //   wr f3 addr          wdata         exp_rdata     mis flt lat rd wr exp_wdata   idx word
    add(0, 0, 32'h17,  32'h0,        32'hFFFFFF88, 0, 0, 2, 1, 0, 32'h0,        5,  32'h8899AABB);
    add(0, 4, 32'h16,  32'h0,        32'h00000099, 0, 0, 2, 1, 0, 32'h0,        5,  32'h8899AABB);
    add(0, 1, 32'h14,  32'h0,        32'hFFFFAABB, 0, 0, 2, 1, 0, 32'h0,        5,  32'h8899AABB);
    add(0, 2, 32'h14,  32'h0,        32'h8899AABB, 0, 0, 2, 1, 0, 32'h0,        5,  32'h8899AABB);
    add(0, 5, 32'h16,  32'h0,        32'h00008899, 0, 0, 2, 1, 0, 32'h0,        5,  32'h8899AABB);
    add(0, 0, 32'h14,  32'h0,        32'hFFFFFFBB, 0, 0, 2, 1, 0, 32'h0,        5,  32'h8899AABB);
    add(0, 4, 32'h15,  32'h0,        32'h000000AA, 0, 0, 2, 1, 0, 32'h0,        5,  32'h8899AABB);
    add(1, 0, 32'h15,  32'h123456CC, 32'h0,        0, 0, 3, 1, 1, 32'h8899CCBB, 5,  32'h8899CCBB);
    add(1, 2, 32'h14,  32'h8899AABB, 32'h0,        0, 0, 2, 0, 1, 32'h8899AABB, 5,  32'h8899AABB);
    add(1, 1, 32'h16,  32'h0000BEEF, 32'h0,        0, 0, 3, 1, 1, 32'hBEEFAABB, 5,  32'hBEEFAABB);
    add(1, 2, 32'h00,  32'hDEADBEEF, 32'h0,        0, 0, 2, 0, 1, 32'hDEADBEEF, 0,  32'hDEADBEEF);
    add(0, 1, 32'h02,  32'h0,        32'hFFFFDEAD, 0, 0, 2, 1, 0, 32'h0,        0,  32'hDEADBEEF);
    add(0, 1, 32'h13,  32'h0,        32'h0,        1, 0, 1, 0, 0, 32'h0,        4,  32'h44444444);
    add(1, 2, 32'h102, 32'hCAFEF00D, 32'h0,        0, 1, 1, 0, 0, 32'h0,        0,  32'hDEADBEEF);
    add(0, 2, 32'h100, 32'h0,        32'h0,        0, 1, 1, 0, 0, 32'h0,        0,  32'hDEADBEEF);
    add(0, 3, 32'h14,  32'h0,        32'h0,        0, 1, 1, 0, 0, 32'h0,        5,  32'hBEEFAABB);
    add(1, 5, 32'h14,  32'h0,        32'h0,        0, 1, 1, 0, 0, 32'h0,        5,  32'hBEEFAABB);
    add(0, 6, 32'h00,  32'h0,        32'h0,        0, 1, 1, 0, 0, 32'h0,        0,  32'hDEADBEEF);
    add(0, 2, 32'hFC,  32'h0,        32'h0A0B0C0D, 0, 0, 2, 1, 0, 32'h0,        63, 32'h0A0B0C0D);
    add(1, 2, 32'h01,  32'h55555555, 32'h0,        1, 0, 1, 0, 0, 32'h0,        0,  32'hDEADBEEF);
    add(1, 0, 32'hFF,  32'h0000005A, 32'h0,        0, 0, 3, 1, 1, 32'h5A0B0C0D, 63, 32'h5A0B0C0D);
    add(0, 0, 32'hFF,  32'h0,        32'h0000005A, 0, 0, 2, 1, 0, 32'h0,        63, 32'h5A0B0C0D);

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check("rst req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("rst resp_rdata", bus.resp_rdata, 32'h0);
    check("rst flags", {30'h0, bus.resp_misaligned, bus.resp_fault}, 32'h0);
    check("rst strobes", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
    check("rst mem_addr", bus.mem_addr, 32'h0);
    check("rst mem_wdata", bus.mem_wdata, 32'h0);
    check("rst state", {30'h0, dbg_state}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mem_init = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset while the write of an SB read-modify-write is on the bus.
    drive_req(1'b1, 3'd0, 32'h14, 32'h00000077);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("abort in RD", {31'h0, bus.mem_read}, 32'h1);
    @(posedge clk);
    #1;
    check("abort in WR", {31'h0, bus.mem_write}, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("abort mem_write", {31'h0, bus.mem_write}, 32'h0);
    check("abort mem_addr", bus.mem_addr, 32'h0);
    check("abort mem_wdata", bus.mem_wdata, 32'h0);
    check("abort resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("abort state", {30'h0, dbg_state}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("abort word unchanged", mem[5], 32'hBEEFAABB);

    // Back-to-back loads with req_valid held high.
    resp_seen = '0; ready_seen = '0; read_seen = '0; rd_a = 32'h0; rd_b = 32'h0;
    drive_req(1'b0, 3'd2, 32'h14, 32'h0);
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(posedge clk);
      #1;
      resp_seen[k-1]  = bus.resp_valid;
      ready_seen[k-1] = bus.req_ready;
      read_seen[k-1]  = bus.mem_read;
      if (k == 2) rd_a = bus.resp_rdata;
      if (k == 5) rd_b = bus.resp_rdata;
    end
    bus.req_valid = 1'b0;
    check("b2b resp pattern", {27'h0, resp_seen}, 32'b10010);
    check("b2b ready pattern", {27'h0, ready_seen}, 32'b00100);
    check("b2b read pattern", {27'h0, read_seen}, 32'b01001);
    check("b2b first rdata", rd_a, 32'hBEEFAABB);
    check("b2b second rdata", rd_b, 32'hBEEFAABB);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
